// File: rtl/i2c_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with stall watchdog, placed in front of
// the I2C controller's single slave port. The grant is held for a whole cycle.
module i2c_wb_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;       // 1 = m1 owned the bus most recently
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;

  logic        own_m1;
  logic        own_cyc, own_stb, own_we;
  logic [3:0]  own_sel;
  logic [31:0] own_adr, own_dat;
  logic        active;
  logic        stall;
  logic        wdog_hit;
  logic        pick_m1;

  assign own_m1  = grant_q[1];
  assign own_cyc = own_m1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own_m1 ? m1_stb_i : m0_stb_i;
  assign own_we  = own_m1 ? m1_we_i  : m0_we_i;
  assign own_sel = own_m1 ? m1_sel_i : m0_sel_i;
  assign own_adr = own_m1 ? m1_adr_i : m0_adr_i;
  assign own_dat = own_m1 ? m1_dat_i : m0_dat_i;

  assign active   = (state_q == ST_ACTIVE);
  assign stall    = active && own_stb && !s_ack_i;
  // Abort on the stalled cycle that would bring the count up to TIMEOUT; an ack
  // in that same cycle clears the stall and therefore wins.
  assign wdog_hit = (TIMEOUT != 0) && ((int'(wdog_q) + 1) == TIMEOUT);
  assign pick_m1  = m1_cyc_i && (!m0_cyc_i || !last_q);

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = ST_ACTIVE;
          grant_d = pick_m1 ? 2'b10 : 2'b01;
        end
      end
      ST_ACTIVE: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          last_d  = own_m1;
          wdog_d  = '0;
        end else if (stall && wdog_hit) begin
          state_d   = ST_HOLDOFF;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          wdog_d    = '0;
        end else if (stall) begin
          if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
        end else begin
          wdog_d = '0;
        end
      end
      ST_HOLDOFF: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          last_d  = own_m1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign s_cyc_o = active && own_cyc;
  assign s_stb_o = active && own_stb;
  assign s_we_o  = active && own_we;
  assign s_sel_o = active ? own_sel : 4'h0;
  assign s_adr_o = active ? own_adr : 32'h0;
  assign s_dat_o = active ? own_dat : 32'h0;

  // Responses reach only the owner, and only while ACTIVE, so a late ack in
  // HOLDOFF is dropped and err/ack can never coincide.
  assign m0_ack_o = active && grant_q[0] && s_ack_i;
  assign m1_ack_o = active && grant_q[1] && s_ack_i;
  assign m0_dat_o = (active && grant_q[0]) ? s_dat_i : 32'h0;
  assign m1_dat_o = (active && grant_q[1]) ? s_dat_i : 32'h0;
  assign m0_err_o = err_q && grant_q[0];
  assign m1_err_o = err_q && grant_q[1];

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Directed bench for i2c_wb_arbiter with TIMEOUT=4: reset, single master, ties,
// burst lock, watchdog abort, ack-at-boundary and reset mid-transfer.
module tb_i2c_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        tmo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_wb_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = 32'h0; m0_wdat = 32'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = 32'h0; m1_wdat = 32'h0;
    s_ack = 0; s_rdat = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_rdat = 32'hCAFE_0001;
    rst = 1'b1;
    step();
    step();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    total++; if ({s_cyc, s_stb, s_adr} !== 34'h0) begin bad++; $display("FAIL reset_slave: got cyc=%b stb=%b adr=%h want 0", s_cyc, s_stb, s_adr); end
    total++; if ({m0_ack, m0_err, m0_rdat} !== 34'h0) begin bad++; $display("FAIL reset_m0: got ack=%b err=%b dat=%h want 0", m0_ack, m0_err, m0_rdat); end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_single();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h0000_0004; m0_wdat = 32'h0000_00A5;
    #1;
    total++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin bad++; $display("FAIL single_pregrant: got grant=%b s_cyc=%b want 00/0", grant, s_cyc); end
    step();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", grant); end
    total++; if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat} !== {3'b111, 4'hF, 32'h4, 32'hA5}) begin
      bad++; $display("FAIL single_mirror: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h", s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat);
    end
    total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL single_noack: got %b want 0", m0_ack); end
    step();
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    #1;
    total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin bad++; $display("FAIL single_ack: got ack=%b err=%b want 1/0", m0_ack, m0_err); end
    total++; if ({m1_ack, m1_err, m1_rdat} !== 34'h0) begin bad++; $display("FAIL single_m1_quiet: got ack=%b err=%b dat=%h want 0", m1_ack, m1_err, m1_rdat); end
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    total++; if (m0_ack !== 1'b0 || s_cyc !== 1'b0) begin bad++; $display("FAIL single_end: got ack=%b s_cyc=%b want 0/0", m0_ack, s_cyc); end
    step();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_release: got %b want 00", grant); end
    idle_inputs();
  endtask

  task automatic test_tie();
    idle_inputs();
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    step();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL tie_first: got %b want 01", grant); end
    m0_cyc = 0;
    step();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL tie_gap: got %b want 00", grant); end
    step();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL tie_second: got %b want 10", grant); end
    m1_cyc = 0;
    step();
    step();
    m0_cyc = 1; m1_cyc = 1;
    step();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL tie_alternate: got %b want 01", grant); end
    m0_cyc = 0; m1_cyc = 0;
    step();
    step();
  endtask

  task automatic test_burst();
    logic [31:0] rd [3];
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_00F0;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_sel = 4'hF; m1_adr = 32'h0000_0008;
    step();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL burst_grant: got %b want 10", grant); end
    total++; if (s_adr !== 32'h8) begin bad++; $display("FAIL burst_adr: got %h want 00000008", s_adr); end
    for (int i = 0; i < 3; i++) begin
      s_ack = 1; s_rdat = rd[i];
      #1;
      total++; if (m1_ack !== 1'b1 || m1_rdat !== rd[i]) begin bad++; $display("FAIL burst_beat%0d: got ack=%b dat=%h want 1/%h", i, m1_ack, m1_rdat, rd[i]); end
      total++; if (m0_ack !== 1'b0 || m0_rdat !== 32'h0) begin bad++; $display("FAIL burst_m0_stall%0d: got ack=%b dat=%h want 0/0", i, m0_ack, m0_rdat); end
      step();
    end
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL burst_hold: got %b want 10", grant); end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL burst_release: got %b want 00", grant); end
    step();
    total++; if (grant !== 2'b01 || s_adr !== 32'hF0) begin bad++; $display("FAIL burst_m0_next: got grant=%b adr=%h want 01/000000f0", grant, s_adr); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_watchdog();
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    step();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL wd_grant: got %b want 01", grant); end
    step(); step(); step();
    total++; if ({m0_err, tmo, s_cyc} !== 3'b001) begin bad++; $display("FAIL wd_pre: got err=%b tmo=%b s_cyc=%b want 0/0/1", m0_err, tmo, s_cyc); end
    step();
    total++; if ({m0_err, tmo, s_cyc, s_stb, m0_ack} !== 5'b11000) begin
      bad++; $display("FAIL wd_abort: got err=%b tmo=%b s_cyc=%b s_stb=%b ack=%b want 1/1/0/0/0", m0_err, tmo, s_cyc, s_stb, m0_ack);
    end
    s_ack = 1; s_rdat = 32'h77;
    #1;
    total++; if (m0_ack !== 1'b0 || m0_rdat !== 32'h0) begin bad++; $display("FAIL wd_late_ack: got ack=%b dat=%h want 0/0", m0_ack, m0_rdat); end
    step();
    total++; if ({m0_err, tmo, m0_ack, s_cyc} !== 4'b0000 || grant !== 2'b01) begin
      bad++; $display("FAIL wd_holdoff: got err=%b tmo=%b ack=%b s_cyc=%b grant=%b want 0/0/0/0/01", m0_err, tmo, m0_ack, s_cyc, grant);
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL wd_idle: got %b want 00", grant); end
    idle_inputs();
  endtask

  task automatic test_ack_boundary();
    idle_inputs();
    m0_cyc = 1; m0_stb = 1;
    step();
    step(); step(); step();
    s_ack = 1; s_rdat = 32'h44;
    #1;
    total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdat !== 32'h44) begin bad++; $display("FAIL bnd_ack: got ack=%b err=%b dat=%h want 1/0/44", m0_ack, m0_err, m0_rdat); end
    step();
    s_ack = 0;
    #1;
    total++; if ({tmo, m0_err, s_cyc} !== 3'b001 || grant !== 2'b01) begin
      bad++; $display("FAIL bnd_no_abort: got tmo=%b err=%b s_cyc=%b grant=%b want 0/0/1/01", tmo, m0_err, s_cyc, grant);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL bnd_release: got %b want 00", grant); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
    step();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL rmid_grant: got %b want 10", grant); end
    step(); step();
    rst = 1; s_ack = 1; s_rdat = 32'h55;
    step();
    total++; if ({grant, tmo, s_cyc, s_stb} !== 5'b00000) begin bad++; $display("FAIL rmid_reset: got grant=%b tmo=%b s_cyc=%b s_stb=%b want 00/0/0/0", grant, tmo, s_cyc, s_stb); end
    total++; if ({m1_ack, m1_err, m1_rdat} !== 34'h0) begin bad++; $display("FAIL rmid_m1: got ack=%b err=%b dat=%h want 0", m1_ack, m1_err, m1_rdat); end
    rst = 0; s_ack = 0; m1_stb = 0; m0_cyc = 1;
    step();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL rmid_tie: got %b want 01", grant); end
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_watchdog();
    test_ack_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
